// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer that shares one combinational 4-bit ALU between two requesters.
// Define ALU_ARB_STATS_EN to add the saturating grant counters gnt0_cnt/gnt1_cnt.
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_req_valid,
    output logic       r0_req_ready,
    input  logic [3:0] r0_req_a,
    input  logic [3:0] r0_req_b,
    input  logic [1:0] r0_req_op,
    output logic       r0_rsp_valid,
    input  logic       r0_rsp_ready,
    output logic [3:0] r0_rsp_data,
    input  logic       r1_req_valid,
    output logic       r1_req_ready,
    input  logic [3:0] r1_req_a,
    input  logic [3:0] r1_req_b,
    input  logic [1:0] r1_req_op,
    output logic       r1_rsp_valid,
    input  logic       r1_rsp_ready,
    output logic [3:0] r1_rsp_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_ctrl,
    input  logic [3:0] alu_c,
    output logic       busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0] gnt0_cnt,
    output logic [7:0] gnt1_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t     state, state_nxt;
    logic       ptr, win, gnt0, gnt1, accept, settle_done, rsp_hs;
    logic [3:0] cnt, result;

    // ptr=0 favours requester 0 when both are valid
    assign gnt0        = state == IDLE && r0_req_valid && (!r1_req_valid || !ptr);
    assign gnt1        = state == IDLE && r1_req_valid && (!r0_req_valid || ptr);
    assign accept      = gnt0 || gnt1;
    assign settle_done = cnt == 4'(SETTLE_CYCLES - 1);
    assign rsp_hs      = state == RESP && (win ? r1_rsp_ready : r0_rsp_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE && accept)      ? EXEC :
                    (state == EXEC && settle_done) ? RESP :
                    (state == RESP && rsp_hs)      ? IDLE : state;
    end

    always_comb begin
        r0_req_ready = gnt0;
        r1_req_ready = gnt1;
        r0_rsp_valid = state == RESP && !win;
        r1_rsp_valid = state == RESP && win;
        r0_rsp_data  = r0_rsp_valid ? result : 4'd0;
        r1_rsp_data  = r1_rsp_valid ? result : 4'd0;
        busy         = state != IDLE;
    end

    // ALU pins are the operand latches, so they stay put through EXEC and RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= 1'b0;
            win      <= 1'b0;
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
            alu_ctrl <= 2'd0;
            cnt      <= 4'd0;
            result   <= 4'd0;
        end else begin
            if (accept) begin
                alu_a    <= gnt1 ? r1_req_a : r0_req_a;
                alu_b    <= gnt1 ? r1_req_b : r0_req_b;
                alu_ctrl <= gnt1 ? r1_req_op : r0_req_op;
                win      <= gnt1;
                cnt      <= 4'd0;
            end else if (state == EXEC) begin
                cnt <= cnt + 4'd1;
            end
            if (state == EXEC && settle_done) result <= alu_c;
            if (rsp_hs) ptr <= !win;
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt0_cnt <= 8'd0;
            gnt1_cnt <= 8'd0;
        end else begin
            if (gnt0 && gnt0_cnt != 8'hFF) gnt0_cnt <= gnt0_cnt + 8'd1;
            if (gnt1 && gnt1_cnt != 8'hFF) gnt1_cnt <= gnt1_cnt + 8'd1;
        end
    end
`endif
endmodule
